// File: rtl/cla_chain_ctrl_pkg.sv
// cla_chain_ctrl_pkg: shared defaults and FSM encoding for the sliced CLA adder
package cla_chain_ctrl_pkg;
  localparam int DEF_SLICE_W = 5;
  localparam int DEF_NUM_SLICES = 4;
  localparam int DEF_CLA_LAT = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/cla_chain_ctrl_cla.sv
// cla_chain_ctrl_cla: registered carry-lookahead slice adder, result valid CLA_LAT edges after the controller drives it
module cla_chain_ctrl_cla import cla_chain_ctrl_pkg::*; #(
  parameter int W = DEF_SLICE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W-1:0] p, g;
  logic [W:0] c;
  assign p = a ^ b;
  assign g = a & b;
  // each carry is a flat sum of generate terms gated by the propagate run below it
  always_comb begin
    logic acc, run;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      acc = g[i];
      run = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      c[i+1] = acc | (run & cin);
    end
  end
  // output register; the controller drives a/b/cin from registers, so one stage gives two-edge latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      cout <= 1'b0;
    end else begin
      s <= p ^ c[W-1:0];
      cout <= c[W];
    end
endmodule

// File: rtl/cla_chain_ctrl.sv
// cla_chain_ctrl: adds wide operands one CLA slice at a time, chaining carry between slices
module cla_chain_ctrl import cla_chain_ctrl_pkg::*; #(
  parameter int SLICE_W = DEF_SLICE_W,
  parameter int NUM_SLICES = DEF_NUM_SLICES,
  parameter int CLA_LAT = DEF_CLA_LAT,
  localparam int W = SLICE_W * NUM_SLICES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic               out_cout,
  output logic               busy,
  output logic [SLICE_W-1:0] cla_a,
  output logic [SLICE_W-1:0] cla_b,
  output logic               cla_cin,
  input  logic [SLICE_W-1:0] cla_s,
  input  logic               cla_cout
);
  localparam int IDX_W = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  localparam int CNT_W = $clog2(CLA_LAT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SLICES - 1);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] op_a, op_b;
  logic carry;
  // sequencer: CLA results are sampled purely by counter, so stale pipeline contents never matter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      idx <= '0;
      cnt <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
      cla_a <= '0;
      cla_b <= '0;
      cla_cin <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          op_a <= in_a;
          op_b <= in_b;
          carry <= in_cin;
          idx <= '0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cla_a <= op_a[idx*SLICE_W +: SLICE_W];
          cla_b <= op_b[idx*SLICE_W +: SLICE_W];
          cla_cin <= carry;
          cnt <= CNT_W'(CLA_LAT);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            out_sum[idx*SLICE_W +: SLICE_W] <= cla_s;
            carry <= cla_cout;
            if (idx == IDX_LAST) begin
              out_cout <= cla_cout;
              out_valid <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule
